bits_skid_buffer: RTL

- Registered ready/valid stage placed directly downstream of the Buf that carries the constant Bits value.
- Decouples the producer from the consumer with a 2-entry skid: the main register plus one skid register.
- Gives 1-cycle forward latency with no combinational path from O_ready to I_ready.
- Intended as the standard output stage for wired Bits constants and buffered Bits buses.

---
 rtl/bits_stage_pkg.sv | 15 +
 rtl/bits_reg_arst.sv | 19 +
 rtl/bits_skid_buffer.sv | 86 ++++++++
 3 files changed

// File: rtl/bits_stage_pkg.sv
// Shared definitions for ready/valid Bits stages: occupancy encoding
// ({skid_valid, main_valid}) and the handshake fire helper.
package bits_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } stage_state_e;

    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/bits_reg_arst.sv
// Width/init-parameterised register with clock enable and asynchronous
// active-low reset to init.
module bits_reg_arst #(
    parameter int               width = 1,
    parameter logic [width-1:0] init  = '0
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             en,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) q <= init;
        else if (en)      q <= d;
    end

endmodule

// File: rtl/bits_skid_buffer.sv
// Two-entry registered ready/valid skid stage: 1-cycle latency, full
// throughput, and I_ready depends only on registered state.
module bits_skid_buffer #(
    parameter int               width = 2,
    parameter logic [width-1:0] init  = '0
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [width-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [width-1:0] O,
    output logic             O_valid,
    input  logic             O_ready
);
    import bits_stage_pkg::*;

    logic [width-1:0] main_data, skid_data, main_d;
    logic             main_valid, skid_valid;
    logic             main_valid_n, skid_valid_n;
    logic             main_en, skid_en;
    logic             in_fire, out_fire;
    stage_state_e     state;

    assign I_ready  = ~skid_valid;
    assign O        = main_data;
    assign O_valid  = main_valid;
    assign in_fire  = fire(I_valid, I_ready);
    assign out_fire = fire(O_valid, O_ready);
    assign state    = stage_state_e'({skid_valid, main_valid});

    always_comb begin
        main_en      = 1'b0;
        skid_en      = 1'b0;
        main_d       = I;
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_en      = 1'b1;
                    main_valid_n = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en      = 1'b1;
                    skid_valid_n = 1'b1;
                end else if (out_fire) begin
                    main_valid_n = 1'b0;
                end
            end
            FULL: begin
                // skid entry moves forward; I_ready is low so nothing new enters
                if (out_fire) begin
                    main_en      = 1'b1;
                    main_d       = skid_data;
                    skid_valid_n = 1'b0;
                end
            end
            default: begin
                main_valid_n = 1'b0;
                skid_valid_n = 1'b0;
            end
        endcase
    end

    bits_reg_arst #(.width(width), .init(init)) u_main_data (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(main_en), .d(main_d), .q(main_data)
    );

    bits_reg_arst #(.width(width), .init(init)) u_skid_data (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(skid_en), .d(I), .q(skid_data)
    );

    bits_reg_arst #(.width(1), .init(1'b0)) u_main_valid (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(1'b1), .d(main_valid_n), .q(main_valid)
    );

    bits_reg_arst #(.width(1), .init(1'b0)) u_skid_valid (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(1'b1), .d(skid_valid_n), .q(skid_valid)
    );

endmodule
